// File: rtl/ibuf_read_sequencer_if.sv
// ---------------------------------------------------------------------------
// ibuf_read_sequencer_if
//   Control/handshake bundle between the input-buffer read-scan sequencer and
//   the read-sync stage it drives.
//   master : the sequencer (takes start/abort/step_ready, drives selects and
//            status strobes)
//   slave  : the surrounding logic (drives requests and step acceptance,
//            observes selects and status)
// Signals
//   start_i            scan request pulse
//   abort_i            terminate scan
//   step_ready_i       downstream accepts current select this cycle
//   raddr_rst_o        read-address reset pulse
//   ctrl_regnum_sel_o  current register number
//   ctrl_regbit_sel_o  current bit-group select
//   sel_valid_o        selects are valid
//   data_valid_o       accepted step, delayed to match sync-stage latency
//   last_o             current step is the final pair of the scan
//   busy_o             scan in progress
//   done_o             one-cycle pulse on normal completion
// ---------------------------------------------------------------------------
interface ibuf_read_sequencer_if;
  logic       start_i;
  logic       abort_i;
  logic       step_ready_i;
  logic       raddr_rst_o;
  logic [3:0] ctrl_regnum_sel_o;
  logic [2:0] ctrl_regbit_sel_o;
  logic       sel_valid_o;
  logic       data_valid_o;
  logic       last_o;
  logic       busy_o;
  logic       done_o;

  modport master (
    input  start_i, abort_i, step_ready_i,
    output raddr_rst_o, ctrl_regnum_sel_o, ctrl_regbit_sel_o,
           sel_valid_o, data_valid_o, last_o, busy_o, done_o
  );

  modport slave (
    output start_i, abort_i, step_ready_i,
    input  raddr_rst_o, ctrl_regnum_sel_o, ctrl_regbit_sel_o,
           sel_valid_o, data_valid_o, last_o, busy_o, done_o
  );
endinterface

// File: rtl/ibuf_read_sequencer.sv
// ---------------------------------------------------------------------------
// ibuf_read_sequencer
//   Read-scan controller for the input buffer's register bank. A start pulse
//   clears the read address, then every (register, bit-group) pair is walked
//   in order, advancing one pair per downstream accept. A LAT-deep strobe
//   pipe marks when read data for each accepted pair becomes valid.
// Parameters
//   NUM_REGS      registers scanned (1..16)
//   BITS_PER_REG  bit-group selects per register (1..8)
//   LAT           select-to-data latency of the sync stage (1..4)
// Ports
//   SYS_CLK   clock
//   SYS_NRST  asynchronous active-low reset
//   bus       ibuf_read_sequencer_if.master (requests in, selects/status out)
// ---------------------------------------------------------------------------
module ibuf_read_sequencer #(
  parameter int NUM_REGS     = 16,
  parameter int BITS_PER_REG = 8,
  parameter int LAT          = 1
) (
  input  logic                          SYS_CLK,
  input  logic                          SYS_NRST,
  ibuf_read_sequencer_if.master         bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0] LAST_REG   = 4'(NUM_REGS - 1);
  localparam logic [2:0] LAST_BIT   = 3'(BITS_PER_REG - 1);
  localparam logic [1:0] LAST_DRAIN = 2'(LAT - 1);

  state_t         state;
  state_t         state_nxt;
  logic [3:0]     regnum;
  logic [2:0]     regbit;
  logic [1:0]     drain_cnt;
  logic [LAT-1:0] dv_pipe;
  logic           accept;
  logic           final_pair;

  assign accept     = (state == S_SCAN) && bus.step_ready_i;
  assign final_pair = (regnum == LAST_REG) && (regbit == LAST_BIT);

  // State register
  // NOTE: every clocked process uses non-blocking (<=) so all flops update
  // together from pre-edge values; blocking here would create order races.
  always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) state <= S_IDLE;
    else           state <= state_nxt;
  end

  // Next-state logic; abort overrides every other input in every state.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    if (bus.abort_i) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  if (bus.start_i) state_nxt = S_CLR;
        S_CLR:   state_nxt = S_SCAN;
        S_SCAN:  if (accept && final_pair) state_nxt = S_DRAIN;
        S_DRAIN: if (drain_cnt == LAST_DRAIN) state_nxt = S_DONE;
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Select counters: advance on accept, hold the final pair through DRAIN,
  // and return to (0,0) whenever the scan is not active.
  always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      regnum <= '0;
      regbit <= '0;
    end else if (state_nxt inside {S_IDLE, S_CLR, S_DONE}) begin
      regnum <= '0;
      regbit <= '0;
    end else if (accept && !final_pair) begin
      if (regbit == LAST_BIT) begin
        regbit <= '0;
        regnum <= regnum + 4'd1;
      end else begin
        regbit <= regbit + 3'd1;
      end
    end
  end

  // DRAIN lasts exactly LAT cycles so the last strobe has left the pipe
  // before done_o is raised.
  always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
    if (!SYS_NRST)              drain_cnt <= '0;
    else if (state == S_DRAIN)  drain_cnt <= drain_cnt + 2'd1;
    else                        drain_cnt <= '0;
  end

  // Data-valid delay line; an abort discards strobes already in flight.
  // NOTE: this is a handful of flops, not a RAM, so it is reset with the rest
  // of the control state and needs no separate initialisation.
  always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      dv_pipe <= '0;
    end else if (bus.abort_i) begin
      dv_pipe <= '0;
    end else begin
      dv_pipe[0] <= accept;
      for (int i = 1; i < LAT; i++) dv_pipe[i] <= dv_pipe[i-1];
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    bus.raddr_rst_o       = (state == S_CLR);
    bus.sel_valid_o       = (state == S_SCAN);
    bus.busy_o            = (state != S_IDLE);
    bus.done_o            = (state == S_DONE);
    bus.last_o            = (state == S_SCAN) && final_pair;
    bus.ctrl_regnum_sel_o = regnum;
    bus.ctrl_regbit_sel_o = regbit;
    bus.data_valid_o      = dv_pipe[LAT-1];
  end

endmodule

// File: tb/tb_ibuf_read_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ibuf_read_sequencer
//   Two sequencers (2x2 regs, LAT=1 and 16x8 regs, LAT=3) driven by the same
//   inputs and compared every cycle against a scan-level reference model.
// ---------------------------------------------------------------------------
module tb_ibuf_read_sequencer;

  logic SYS_CLK  = 1'b0;
  logic SYS_NRST = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  ibuf_read_sequencer_if bus0 ();
  ibuf_read_sequencer_if bus1 ();

  ibuf_read_sequencer #(.NUM_REGS(2), .BITS_PER_REG(2), .LAT(1)) dut0 (
    .SYS_CLK (SYS_CLK),
    .SYS_NRST(SYS_NRST),
    .bus     (bus0)
  );

  ibuf_read_sequencer #(.NUM_REGS(16), .BITS_PER_REG(8), .LAT(3)) dut1 (
    .SYS_CLK (SYS_CLK),
    .SYS_NRST(SYS_NRST),
    .bus     (bus1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (scan level) ----------------
  localparam int MAXE    = 8192;
  localparam int P_IDLE  = 0;
  localparam int P_CLR   = 1;
  localparam int P_SCAN  = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE  = 4;

  int cfg_n[2] = '{2, 16};
  int cfg_b[2] = '{2, 8};
  int cfg_l[2] = '{1, 3};

  int ph[2];          // scan phase
  int k[2];           // index of current pair in scan order
  int dleft[2];       // drain cycles remaining
  int flush_edge[2];  // accepts before this edge never show as data_valid
  bit acc_hist[2][MAXE];
  int edge_n = 0;

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      ph[d] = P_IDLE; k[d] = 0; dleft[d] = 0; flush_edge[d] = edge_n + 1;
    end
  endfunction

  function automatic void model_step(input bit s, input bit a, input bit r);
    edge_n++;
    for (int d = 0; d < 2; d++) begin
      bit acc = 1'b0;
      if (a) begin
        ph[d] = P_IDLE; k[d] = 0; flush_edge[d] = edge_n + 1;
      end else begin
        case (ph[d])
          P_IDLE:  if (s) ph[d] = P_CLR;
          P_CLR:   begin ph[d] = P_SCAN; k[d] = 0; end
          P_SCAN:  if (r) begin
                     acc = 1'b1;
                     if (k[d] == cfg_n[d] * cfg_b[d] - 1) begin
                       ph[d] = P_DRAIN; dleft[d] = cfg_l[d];
                     end else begin
                       k[d]++;
                     end
                   end
          P_DRAIN: begin dleft[d]--; if (dleft[d] == 0) ph[d] = P_DONE; end
          default: ph[d] = P_IDLE;
        endcase
      end
      acc_hist[d][edge_n] = acc;
    end
  endfunction

  // {raddr_rst, regnum[3:0], regbit[2:0], sel_valid, data_valid, last, busy, done}
  function automatic logic [12:0] model_out(input int d);
    int  src = edge_n - cfg_l[d] + 1;  // edge whose accept surfaces now
    bit  dv  = (src >= flush_edge[d]) ? acc_hist[d][src] : 1'b0;
    bit  act = (ph[d] == P_SCAN) || (ph[d] == P_DRAIN);
    logic [3:0] rn = act ? 4'(k[d] / cfg_b[d]) : 4'd0;
    logic [2:0] rb = act ? 3'(k[d] % cfg_b[d]) : 3'd0;
    return {ph[d] == P_CLR, rn, rb, ph[d] == P_SCAN, dv,
            (ph[d] == P_SCAN) && (k[d] == cfg_n[d] * cfg_b[d] - 1),
            ph[d] != P_IDLE, ph[d] == P_DONE};
  endfunction

  function automatic logic [12:0] dut_out(input int d);
    if (d == 0)
      return {bus0.raddr_rst_o, bus0.ctrl_regnum_sel_o, bus0.ctrl_regbit_sel_o, bus0.sel_valid_o,
              bus0.data_valid_o, bus0.last_o, bus0.busy_o, bus0.done_o};
    return {bus1.raddr_rst_o, bus1.ctrl_regnum_sel_o, bus1.ctrl_regbit_sel_o, bus1.sel_valid_o,
            bus1.data_valid_o, bus1.last_o, bus1.busy_o, bus1.done_o};
  endfunction

  // Drive inputs (called at negedge), advance one clock, compare at negedge.
  task automatic tick(input bit s, input bit a, input bit r);
    if (edge_n >= MAXE - 2) begin
      $display("FAIL edge_budget: got=%0d limit=%0d", edge_n, MAXE);
      $fatal(1, "edge budget exhausted");
    end
    bus0.start_i = s; bus0.abort_i = a; bus0.step_ready_i = r;
    bus1.start_i = s; bus1.abort_i = a; bus1.step_ready_i = r;
    model_step(s, a, r);
    @(posedge SYS_CLK);
    @(negedge SYS_CLK);
    for (int d = 0; d < 2; d++)
      check($sformatf("dut%0d_edge%0d", d, edge_n), 32'(dut_out(d)), 32'(model_out(d)));
  endtask

  initial begin
    int e0, done_e, last_e, idle_e, holds, accs, dones, dvs;
    bit aborted, r, s;
    logic [6:0] last_pair;

    bus0.start_i = 0; bus0.abort_i = 0; bus0.step_ready_i = 0;
    bus1.start_i = 0; bus1.abort_i = 0; bus1.step_ready_i = 0;

    // Reset state
    @(negedge SYS_CLK);
    check("reset_dut0", 32'(dut_out(0)), 32'd0);
    check("reset_dut1", 32'(dut_out(1)), 32'd0);
    SYS_NRST = 1'b1;
    model_reset();
    tick(0, 0, 0);

    // A: 2x2 scan, ready always high
    tick(0, 1, 0);
    e0 = edge_n + 1; done_e = -1; last_e = -1; idle_e = -1;
    tick(1, 0, 1);
    check("A_raddr_rst_cyc1", 32'(bus0.raddr_rst_o), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 1);
      if (bus0.last_o && last_e < 0) last_e = edge_n;
      if (bus0.done_o && done_e < 0) done_e = edge_n;
      if (done_e >= 0 && !bus0.busy_o && idle_e < 0) idle_e = edge_n;
    end
    check("A_last_cycle", 32'(last_e - e0), 32'd4);
    check("A_done_cycle", 32'(done_e - e0), 32'd6);
    check("A_idle_cycle", 32'(idle_e - e0), 32'd7);

    // B: ready low for 3 cycles while step (0,1) is presented
    tick(0, 1, 0);
    e0 = edge_n + 1; done_e = -1; holds = 0; accs = 0;
    tick(1, 0, 1);
    for (int i = 0; i < 16; i++) begin
      r = !(bus0.sel_valid_o && bus0.ctrl_regnum_sel_o == 4'd0 &&
            bus0.ctrl_regbit_sel_o == 3'd1 && holds < 3);
      if (!r) holds++;
      if (bus0.sel_valid_o && r) accs++;
      tick(0, 0, r);
      if (bus0.done_o && done_e < 0) done_e = edge_n;
    end
    check("B_accepts", 32'(accs), 32'd4);
    check("B_done_cycle", 32'(done_e - e0), 32'd9);

    // C: abort while step (1,0) is presented, then start+abort in IDLE
    tick(0, 1, 0);
    aborted = 0; dones = 0;
    tick(1, 0, 1);
    for (int i = 0; i < 10 && !aborted; i++) begin
      if (bus0.sel_valid_o && bus0.ctrl_regnum_sel_o == 4'd1 && bus0.ctrl_regbit_sel_o == 3'd0) begin
        tick(0, 1, 1);
        aborted = 1;
      end else begin
        tick(0, 0, 1);
      end
    end
    check("C_abort_reached", 32'(aborted), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 1);
      if (bus0.done_o) dones++;
    end
    check("C_no_done", 32'(dones), 32'd0);
    tick(1, 1, 0);
    check("C_start_abort_idle", 32'(bus0.busy_o), 32'd0);

    // D: start re-pulsed while scanning and in DONE
    tick(0, 1, 0);
    dones = 0;
    tick(1, 0, 1);
    for (int i = 0; i < 14; i++) begin
      s = bus0.sel_valid_o | bus0.done_o;
      tick(s, 0, 1);
      if (bus0.done_o) dones++;
    end
    check("D_single_done", 32'(dones), 32'd1);

    // E: full 16x8 scan with random ready
    tick(0, 1, 0);
    accs = 0; dvs = 0; dones = 0; last_pair = '0;
    tick(1, 0, 1);
    for (int i = 0; i < 3000 && dones == 0; i++) begin
      r = 1'($urandom_range(0, 1));
      if (bus1.sel_valid_o && r) begin
        accs++;
        last_pair = {bus1.ctrl_regnum_sel_o, bus1.ctrl_regbit_sel_o};
      end
      tick(0, 0, r);
      if (bus1.data_valid_o) dvs++;
      if (bus1.done_o) dones++;
    end
    check("E_done_seen", 32'(dones), 32'd1);
    check("E_accepts", 32'(accs), 32'd128);
    check("E_data_valid", 32'(dvs), 32'd128);
    check("E_last_pair", 32'(last_pair), 32'({4'd15, 3'd7}));

    // F: asynchronous reset mid-scan, then a fresh scan
    tick(0, 1, 0);
    tick(1, 0, 1);
    for (int i = 0; i < 5; i++) tick(0, 0, 1);
    #2;
    SYS_NRST = 1'b0;
    #1;
    check("F_async_rst_dut0", 32'(dut_out(0)), 32'd0);
    check("F_async_rst_dut1", 32'(dut_out(1)), 32'd0);
    @(negedge SYS_CLK);
    SYS_NRST = 1'b1;
    model_reset();
    tick(0, 0, 0);
    tick(1, 0, 1);
    tick(0, 0, 1);
    check("F_fresh_sel", 32'({bus1.ctrl_regnum_sel_o, bus1.ctrl_regbit_sel_o, bus1.sel_valid_o}),
          32'({4'd0, 3'd0, 1'b1}));
    for (int i = 0; i < 8; i++) tick(0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
